// File: rtl/shift_seq_ctrl.sv
// Framed full-duplex serial transfer sequencer around a WIDTH-bit shift register.
// Optional even-parity bit phase is enabled by defining SHIFT_SEQ_PARITY_EN.
module shift_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] LOAD_DATA,
    input  logic             RX_IN,
    output logic             TX_OUT,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RX_DATA,
    output logic             PAR_ERR
);

`ifdef SHIFT_SEQ_PARITY_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
`endif

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SHIFT_SEQ_PARITY_EN
    logic             par_q, par_d;
    logic             par_err_q, par_err_d;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            sreg_q    <= '0;
            rx_data_q <= '0;
            cnt_q     <= '0;
`ifdef SHIFT_SEQ_PARITY_EN
            par_q     <= 1'b0;
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            rx_data_q <= rx_data_d;
            cnt_q     <= cnt_d;
`ifdef SHIFT_SEQ_PARITY_EN
            par_q     <= par_d;
            par_err_q <= par_err_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        rx_data_d = rx_data_q;
        cnt_d     = cnt_q;
        TX_OUT    = 1'b0;
        BUSY      = 1'b0;
        DONE      = 1'b0;
`ifdef SHIFT_SEQ_PARITY_EN
        par_d     = par_q;
        par_err_d = par_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    sreg_d  = LOAD_DATA;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
`ifdef SHIFT_SEQ_PARITY_EN
                    par_d   = ^LOAD_DATA;
`endif
                end
            end
            S_SHIFT: begin
                BUSY   = 1'b1;
                TX_OUT = sreg_q[WIDTH-1];
                sreg_d = {sreg_q[WIDTH-2:0], RX_IN};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
`ifdef SHIFT_SEQ_PARITY_EN
                    state_d = S_PARITY;
`else
                    rx_data_d = sreg_d;
                    state_d   = S_DONE;
`endif
                end
            end
`ifdef SHIFT_SEQ_PARITY_EN
            // Received word is published at the edge entering DONE so it moves
            // together with PAR_ERR; the shift register holds it through PARITY.
            S_PARITY: begin
                BUSY      = 1'b1;
                TX_OUT    = par_q;
                rx_data_d = sreg_q;
                par_err_d = RX_IN ^ (^sreg_q);
                state_d   = S_DONE;
            end
`endif
            S_DONE: begin
                DONE    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign RX_DATA = rx_data_q;
`ifdef SHIFT_SEQ_PARITY_EN
    assign PAR_ERR = par_err_q;
`else
    assign PAR_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Randomized self-checking bench for shift_seq_ctrl against a word-level transfer model.
// Define SHIFT_SEQ_PARITY_EN for both files to exercise the parity phase.
module tb_shift_seq_ctrl;
    localparam int W  = 4;
    localparam int CW = 3;

    logic         CLK = 1'b0;
    logic         RST, START, RX_IN;
    logic [W-1:0] LOAD_DATA;
    logic         TX_OUT, BUSY, DONE, PAR_ERR;
    logic [W-1:0] RX_DATA;

    int unsigned  n_chk = 0;
    int unsigned  n_err = 0;
    logic [W-1:0] exp_rx;
    logic         exp_perr;

    always #5 CLK = ~CLK;

    shift_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST), .START(START), .LOAD_DATA(LOAD_DATA), .RX_IN(RX_IN),
        .TX_OUT(TX_OUT), .BUSY(BUSY), .DONE(DONE), .RX_DATA(RX_DATA), .PAR_ERR(PAR_ERR)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(BUSY), 32'd0);
        check({tag, "_done"}, 32'(DONE), 32'd0);
        check({tag, "_tx"}, 32'(TX_OUT), 32'd0);
        check({tag, "_rxdata"}, 32'(RX_DATA), 32'(exp_rx));
        check({tag, "_perr"}, 32'(PAR_ERR), 32'(exp_perr));
    endtask

    // Called and returns at a negedge with the DUT in IDLE.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            START     = 1'b0;
            RX_IN     = 1'($urandom);
            LOAD_DATA = W'($urandom);
            @(negedge CLK);
            check_idle("idle");
        end
    endtask

    // mode 0: random START noise, 1: START held high, 2: START pulses in cycle 2 and DONE cycle
    task automatic xfer(input logic [W-1:0] load, input logic [W-1:0] rx, input logic rxpar,
                        input int mode);
        START     = 1'b1;
        LOAD_DATA = load;
        for (int c = 1; c <= W; c++) begin
            @(negedge CLK);
            check("sh_busy", 32'(BUSY), 32'd1);
            check("sh_done", 32'(DONE), 32'd0);
            check("sh_tx", 32'(TX_OUT), 32'(load[W-c]));
            check("sh_rxhold", 32'(RX_DATA), 32'(exp_rx));
            check("sh_perr", 32'(PAR_ERR), 32'(exp_perr));
            RX_IN     = rx[W-c];
            LOAD_DATA = W'($urandom);
            START     = (mode == 1) ? 1'b1 : (mode == 2) ? (c == 2) : 1'($urandom);
        end
`ifdef SHIFT_SEQ_PARITY_EN
        @(negedge CLK);
        check("par_busy", 32'(BUSY), 32'd1);
        check("par_done", 32'(DONE), 32'd0);
        check("par_tx", 32'(TX_OUT), 32'(^load));
        check("par_rxhold", 32'(RX_DATA), 32'(exp_rx));
        RX_IN = rxpar;
        START = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : 1'($urandom);
        exp_perr = rxpar ^ (^rx);
`else
        exp_perr = 1'b0;
`endif
        exp_rx = rx;
        @(negedge CLK);
        check("dn_done", 32'(DONE), 32'd1);
        check("dn_busy", 32'(BUSY), 32'd0);
        check("dn_tx", 32'(TX_OUT), 32'd0);
        check("dn_rxdata", 32'(RX_DATA), 32'(exp_rx));
        check("dn_perr", 32'(PAR_ERR), 32'(exp_perr));
        START = (mode == 1 || mode == 2) ? 1'b1 : 1'($urandom);
        RX_IN = 1'($urandom);
        @(negedge CLK);
        check_idle("post");
    endtask

    // Asynchronous reset in the middle of data cycle 3 with START held high throughout.
    task automatic xfer_abort();
        START     = 1'b1;
        LOAD_DATA = W'($urandom);
        for (int c = 1; c <= 3; c++) begin
            @(negedge CLK);
            check("ab_busy", 32'(BUSY), 32'd1);
            RX_IN = 1'($urandom);
        end
        #2 RST = 1'b0;
        #1;
        exp_rx   = '0;
        exp_perr = 1'b0;
        check_idle("rst_async");
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check_idle("rst_hold");
        end
        START = 1'b0;
        RST   = 1'b1;
        @(negedge CLK);
        check_idle("rst_rel");
    endtask

    initial begin
        RST       = 1'b1;
        START     = 1'b0;
        RX_IN     = 1'b0;
        LOAD_DATA = '0;
        exp_rx    = '0;
        exp_perr  = 1'b0;
        #2 RST = 1'b0;
        #1 check_idle("reset");
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check_idle("init");

        xfer(4'b1011, 4'b0110, 1'b0, 2);
        idle_cycles(10);

        xfer(4'hA, W'($urandom), 1'($urandom), 1);
        xfer(4'h5, W'($urandom), 1'($urandom), 1);
        idle_cycles(2);

        xfer_abort();
        xfer(W'($urandom), W'($urandom), 1'($urandom), 0);

`ifdef SHIFT_SEQ_PARITY_EN
        xfer(4'b1011, 4'b1100, 1'b0, 0);
        xfer(4'b1011, 4'b1100, 1'b1, 0);
`endif

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 9) == 0)
                xfer_abort();
            else
                xfer(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 1)));
            idle_cycles(int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Sequencer for the team's 4-bit serial shift register datapath. On a START request it:
- parallel-loads a word;
- clocks it out MSB-first on TX_OUT while shifting RX_IN in at the LSB (full-duplex);
- counts exactly WIDTH shifts, then presents the received word with a one-cycle DONE pulse.

It is the control layer that turns the free-running shift chain into a framed, handshaked serial transfer.

Parameters:
WIDTH, 4, shift register length in bits (≥2)
CNT_W, 3, bit-counter width; must satisfy 2^CNT_W > WIDTH

Ports:
CLK  input  1  system clock, rising edge active
RST  input  1  asynchronous, active-low reset
START  input  1  transfer request, sampled on CLK rising edge
LOAD_DATA  input  WIDTH  parallel word captured when START is accepted
RX_IN  input  1  serial input, sampled each shift edge
TX_OUT  output  1  serial output
BUSY  output  1  high while a transfer is in progress
DONE  output  1  one-cycle pulse: transfer complete, RX_DATA valid
RX_DATA  output  WIDTH  last received word, held until next DONE
PAR_ERR  output  1  parity error flag (see Optional Feature)

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE, shift reg=0, bit count=0, TX_OUT=0, BUSY=0, DONE=0, RX_DATA=0, PAR_ERR=0. Deassertion takes effect at the next CLK edge.
- States: IDLE, SHIFT, PARITY (only with macro), DONE.
- IDLE:
  - START=1 at an edge: reg<=LOAD_DATA, cnt<=0, go SHIFT.
  - START=0: remain in IDLE.
- SHIFT:
  - TX_OUT = reg[WIDTH-1], combinational from the register.
  - Each edge: reg <= {reg[WIDTH-2:0], RX_IN}, cnt <= cnt+1.
  - At the edge where cnt==WIDTH-1: perform the final shift, load RX_DATA with the shifted value, then go DONE (or PARITY with macro).
- DONE: lasts exactly one cycle with DONE=1. Next edge always goes to IDLE, regardless of START.
- BUSY=1 in SHIFT and PARITY only. TX_OUT=0 in IDLE and DONE.
- Latency:
  - START accepted at edge 0.
  - Data bits appear on TX_OUT in cycles 1..WIDTH.
  - DONE is high in cycle WIDTH+1.
  - Earliest next accept is edge WIDTH+2, so back-to-back period is WIDTH+2 cycles.
- START while BUSY or DONE: ignored, not queued. START held high continuously: a new transfer begins at each IDLE.
- RX_DATA changes only at the edge that enters DONE. It is stable at all other times.
- RST asserted mid-transfer: immediate abort to reset values. No DONE is generated. The partial word is discarded.
- LOAD_DATA and RX_IN are don't-care outside their sampling edges.

Optional Feature:
Macro SHIFT_SEQ_PARITY_EN.
- Defined:
  - After the last data shift, FSM enters PARITY for one cycle.
  - TX_OUT = even-parity bit (XOR of the LOAD_DATA word captured at START).
  - RX_IN is sampled at the PARITY edge as the received parity bit.
  - PAR_ERR <= (RX_IN XOR ^RX_DATA); it updates together with the DONE pulse and holds until the next DONE.
  - Period becomes WIDTH+3 cycles. DONE falls in cycle WIDTH+2.
- Undefined: PARITY state and parity logic are absent. PAR_ERR is tied to 0. Timing is as in Behaviour.

Test Plan:
1. WIDTH=4, LOAD_DATA=4'b1011, START pulse at edge 0, RX_IN=0,1,1,0 on edges 1..4 -> TX_OUT=1,0,1,1 in cycles 1..4; BUSY high cycles 1..4; DONE high only in cycle 5; RX_DATA=4'b0110; PAR_ERR=0.
2. START held high, LOAD_DATA=4'hA then 4'h5 -> transfers accepted at edges 0 and 6; TX_OUT=1,0,1,0 then 0,1,0,1; exactly two DONE pulses, in cycles 5 and 11.
3. START pulsed again in cycles 2 and 5 of a transfer -> ignored; exactly one DONE; BUSY waveform unchanged.
4. RST driven low asynchronously mid-cycle 3 of a transfer -> all outputs 0 immediately; no DONE; a new START after release runs a complete correct transfer.
5. With SHIFT_SEQ_PARITY_EN, LOAD_DATA=4'b1011 -> TX_OUT=1,0,1,1,1. RX_IN=1,1,0,0 then parity 0 -> RX_DATA=4'b1100, PAR_ERR=0, DONE in cycle 6. Same run with parity 1 -> PAR_ERR=1.
6. RX_DATA hold check: after the DONE of scenario 1, toggle RX_IN randomly for 10 idle cycles -> RX_DATA stays 4'b0110; TX_OUT stays 0.
